load_store_unit: RTL and testbench

Load/store unit between the single-cycle core datapath and `data_memory`. It turns byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into whole-word memory accesses. Sub-word stores use a same-cycle read-modify-write over the memory's asynchronous read port. Accesses that cross a word boundary are split into two sequential word accesses, and the core is stalled for one cycle.

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit_byte_lane_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the load/store path: funct3 encodings and
// helpers that decode access size, legality and word-boundary crossing.
package riscv_pkg;

  localparam int DATA_W = 32;

  typedef logic [2:0] funct3_t;

  localparam funct3_t F3_B  = 3'b000;
  localparam funct3_t F3_H  = 3'b001;
  localparam funct3_t F3_W  = 3'b010;
  localparam funct3_t F3_BU = 3'b100;
  localparam funct3_t F3_HU = 3'b101;

  // Access size in bytes (1, 2 or 4); only meaningful for legal funct3.
  function automatic logic [2:0] f3_size(funct3_t f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(logic we, funct3_t f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic crosses(logic [1:0] off, logic [2:0] size);
    return ({1'b0, off} + size) > 3'd4;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and data_memory port bundle of the load/store unit.
interface load_store_unit_if;
  import riscv_pkg::*;

  logic              req_valid;
  logic              req_we;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              err;
  logic              mem_WE;
  logic [DATA_W-1:0] mem_A;
  logic [DATA_W-1:0] mem_WD;
  logic [DATA_W-1:0] mem_RD;

  // master: the core plus data_memory; slave: the load/store unit
  modport master (
    output req_valid, req_we, funct3, addr, wdata, mem_RD,
    input  rdata, stall, err, mem_WE, mem_A, mem_WD
  );

  modport slave (
    input  req_valid, req_we, funct3, addr, wdata, mem_RD,
    output rdata, stall, err, mem_WE, mem_A, mem_WD
  );

endinterface

// File: rtl/load_store_unit_byte_lane_align.sv
// Combinational lane steering: load extraction with sign/zero extension over a
// two-word window, and sub-word store merge into either word of that window.
module byte_lane_align
  import riscv_pkg::*;
(
  input  logic [1:0]        offset,
  input  logic [2:0]        size,
  input  logic              sext,
  input  logic              hi_half,
  input  logic [DATA_W-1:0] word_lo,
  input  logic [DATA_W-1:0] word_hi,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_word
);

  logic [3:0]        size_mask;
  logic [7:0]        lane_mask;
  logic [63:0]       data_sh;
  logic [DATA_W-1:0] win;
  logic signed [7:0]  ld_b;
  logic signed [15:0] ld_h;
  logic [3:0]        wr_mask;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] base;

  always_comb begin
    case (size)
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  // Lanes 0..3 address the low word, lanes 4..7 the following word.
  assign lane_mask = {4'b0000, size_mask} << offset;
  assign data_sh   = {32'b0, data} << {offset, 3'b000};
  assign win       = 32'({word_hi, word_lo} >> {offset, 3'b000});

  assign ld_b = win[7:0];
  assign ld_h = win[15:0];

  always_comb begin
    case (size)
      3'd1:    load_data = sext ? $unsigned(32'(ld_b)) : {24'b0, win[7:0]};
      3'd2:    load_data = sext ? $unsigned(32'(ld_h)) : {16'b0, win[15:0]};
      default: load_data = win;
    endcase
  end

  assign wr_mask = hi_half ? lane_mask[7:4] : lane_mask[3:0];
  assign wr_data = hi_half ? data_sh[63:32] : data_sh[31:0];
  assign base    = hi_half ? word_hi : word_lo;

  always_comb begin
    store_word = base;
    for (int i = 0; i < 4; i++) begin
      if (wr_mask[i]) store_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-addressed loads/stores onto a word memory with
// an async read port; word-crossing accesses are split over two cycles.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter bit SUPPORT_MISALIGNED = 1'b1
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] addr_p1;
  funct3_t           f3_p1;
  logic              we_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [DATA_W-1:0] hold_p1;
  logic              latch_en;

  logic              in_split;
  logic              req_legal;
  logic              req_cross;
  logic [1:0]        al_off;
  funct3_t           al_f3;
  logic [DATA_W-1:0] al_data;
  logic [DATA_W-1:0] al_lo;
  logic [DATA_W-1:0] al_hi;
  logic [DATA_W-1:0] al_load;
  logic [DATA_W-1:0] al_store;

  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              err;
  logic              mem_we;
  logic [DATA_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;

  assign in_split  = (state_q == SPLIT);
  assign req_legal = f3_legal(bus.req_we, bus.funct3);
  assign req_cross = crosses(bus.addr[1:0], f3_size(bus.funct3));

  // In SPLIT the latched request drives the lanes; the window is the held
  // first-word bytes below the second word now on mem_RD.
  assign al_off  = in_split ? addr_p1[1:0] : bus.addr[1:0];
  assign al_f3   = in_split ? f3_p1 : bus.funct3;
  assign al_data = in_split ? wdata_p1 : bus.wdata;
  assign al_lo   = in_split ? hold_p1 : bus.mem_RD;
  assign al_hi   = in_split ? bus.mem_RD : '0;

  byte_lane_align u_align (
    .offset     (al_off),
    .size       (f3_size(al_f3)),
    .sext       (~al_f3[2]),
    .hi_half    (in_split),
    .word_lo    (al_lo),
    .word_hi    (al_hi),
    .data       (al_data),
    .load_data  (al_load),
    .store_word (al_store)
  );

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    rdata    = '0;
    stall    = 1'b0;
    err      = 1'b0;
    mem_we   = 1'b0;
    mem_a    = {bus.addr[31:2], 2'b00};
    mem_wd   = bus.mem_RD;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (!req_legal || (req_cross && !SUPPORT_MISALIGNED)) begin
            err = 1'b1;
          end else if (req_cross) begin
            stall    = 1'b1;
            latch_en = 1'b1;
            mem_we   = bus.req_we;
            mem_wd   = al_store;
            state_d  = SPLIT;
          end else if (bus.req_we) begin
            mem_we = 1'b1;
            mem_wd = al_store;
          end else begin
            rdata = al_load;
          end
        end
      end
      SPLIT: begin
        mem_a   = {addr_p1[31:2], 2'b00} + 32'd4;
        state_d = IDLE;
        if (we_p1) begin
          mem_we = 1'b1;
          mem_wd = al_store;
        end else begin
          rdata = al_load;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      rdata  = '0;
      stall  = 1'b0;
      err    = 1'b0;
      mem_we = 1'b0;
    end
  end

  // Stage boundary: first half of a split access latched for the second cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_p1  <= '0;
      f3_p1    <= '0;
      we_p1    <= 1'b0;
      wdata_p1 <= '0;
      hold_p1  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        addr_p1  <= bus.addr;
        f3_p1    <= bus.funct3;
        we_p1    <= bus.req_we;
        wdata_p1 <= bus.wdata;
        hold_p1  <= bus.mem_RD & (32'hFFFF_FFFF << {bus.addr[1:0], 3'b000});
      end
    end
  end

  assign bus.rdata  = rdata;
  assign bus.stall  = stall;
  assign bus.err    = err;
  assign bus.mem_WE = mem_we;
  assign bus.mem_A  = mem_a;
  assign bus.mem_WD = mem_wd;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed test-plan steps plus randomized accesses
// scored against a byte-addressed memory model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  load_store_unit_if bus0 ();

  load_store_unit #(.SUPPORT_MISALIGNED(1'b1)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  load_store_unit #(.SUPPORT_MISALIGNED(1'b0)) dut0 (
    .clk (clk),
    .rst (rst_n),
    .bus (bus0)
  );

  // 16-word data memory (addresses alias modulo 64 bytes) with a backdoor port.
  logic [31:0] mem [16];
  logic        bb_we;
  logic [3:0]  bb_idx;
  logic [31:0] bb_val;

  assign bus.mem_RD  = mem[bus.mem_A[5:2]];
  assign bus0.mem_RD = 32'h5A5A_5A5A;

  always @(posedge clk) begin
    if (bb_we) mem[bb_idx] <= bb_val;
    else if (bus.mem_WE) mem[bus.mem_A[5:2]] <= bus.mem_WD;
  end

  // Reference: plain byte array, same 64-byte aliasing.
  logic [7:0] ref_mem [64];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rd, a1;
  logic        st0;
  logic [2:0]  ld_f3  [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0]  ill_ld [3] = '{3'b011, 3'b110, 3'b111};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int f3_bytes(logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic ref_legal(logic we, logic [2:0] f3);
    if (we) return f3 inside {3'b000, 3'b001, 3'b010};
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, logic [2:0] f3);
    int n = f3_bytes(f3);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(a[5:0]) + i) % 64];
    if (!f3[2] && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) ref_mem[(int'(a[5:0]) + i) % 64] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(int idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    bb_we = 1'b1; bb_idx = 4'(idx); bb_val = val;
    @(posedge clk);
    #1 bb_we = 1'b0;
    for (int b = 0; b < 4; b++) ref_mem[4*idx+b] = val[8*b +: 8];
  endtask

  task automatic preload();
    poke(0, 32'h4433_2211);
    poke(1, 32'h8877_6655);
    poke(2, 32'h0000_0000);
  endtask

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdo,
                        output logic s0, output logic er, output logic we0,
                        output logic [31:0] a0, output logic s1, output logic we1,
                        output logic [31:0] a1o);
    s1 = 'x; we1 = 'x; a1o = 'x;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    #1;
    s0 = bus.stall; er = bus.err; we0 = bus.mem_WE; a0 = bus.mem_A; rdo = bus.rdata;
    @(posedge clk);
    if (s0 === 1'b1) begin
      @(negedge clk);
      bus.addr = $urandom; bus.wdata = $urandom;
      bus.funct3 = 3'($urandom); bus.req_we = 1'($urandom);
      #1;
      rdo = bus.rdata; s1 = bus.stall; we1 = bus.mem_WE; a1o = bus.mem_A;
      @(posedge clk);
    end
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rdo, output logic s0,
                           output logic [31:0] a1o);
    int n;
    logic lg, cr, er, we0, s1, we1;
    logic [31:0] a0, exp_rd;
    n = f3_bytes(f3);
    lg = ref_legal(we, f3);
    cr = (int'(a[1:0]) + n) > 4;
    exp_rd = ref_load(a, f3);
    access(we, f3, a, wd, rdo, s0, er, we0, a0, s1, we1, a1o);
    chk({tag, ".err"}, 32'(er), 32'(!lg));
    if (!lg) begin
      chk({tag, ".we"}, 32'(we0), 32'd0);
      chk({tag, ".stall"}, 32'(s0), 32'd0);
      chk({tag, ".rdata"}, rdo, 32'd0);
    end else begin
      chk({tag, ".stall0"}, 32'(s0), 32'(cr));
      chk({tag, ".addr0"}, a0, {a[31:2], 2'b00});
      chk({tag, ".we0"}, 32'(we0), 32'(we));
      if (cr) begin
        chk({tag, ".addr1"}, a1o, {a[31:2], 2'b00} + 32'd4);
        chk({tag, ".we1"}, 32'(we1), 32'(we));
        chk({tag, ".stall1"}, 32'(s1), 32'd0);
      end
      if (!we) chk({tag, ".rdata"}, rdo, exp_rd);
      else ref_store(a, n, wd);
    end
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    rst_n = 1'b1;
    bb_we = 1'b0; bb_idx = '0; bb_val = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.funct3 = 3'b010;
    bus.addr = '0; bus.wdata = '0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.funct3 = 3'b010;
    bus0.addr = '0; bus0.wdata = '0;
    #1 rst_n = 1'b0;

    for (int i = 0; i < 16; i++) poke(i, 32'h0);

    // Outputs forced quiet while reset is held, even with a live request.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.funct3 = 3'b011; bus.addr = 32'h2;
    #1;
    chk("rst.err", 32'(bus.err), 32'd0);
    chk("rst.stall", 32'(bus.stall), 32'd0);
    chk("rst.rdata", bus.rdata, 32'd0);
    bus.req_we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h6;
    #1;
    chk("rst.we", 32'(bus.mem_WE), 32'd0);
    chk("rst.stall_st", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.req_valid = 1'b0;
    #1;
    chk("idle.stall", 32'(bus.stall), 32'd0);
    chk("idle.we", 32'(bus.mem_WE), 32'd0);
    chk("idle.rdata", bus.rdata, 32'd0);

    preload();
    run_check("LW0", 1'b0, 3'b010, 32'h0, 32'h0, rd, st0, a1);
    chk("LW0.lit", rd, 32'h4433_2211);
    run_check("LB7", 1'b0, 3'b000, 32'h7, 32'h0, rd, st0, a1);
    chk("LB7.lit", rd, 32'hFFFF_FF88);
    run_check("LBU7", 1'b0, 3'b100, 32'h7, 32'h0, rd, st0, a1);
    chk("LBU7.lit", rd, 32'h0000_0088);
    run_check("LH6", 1'b0, 3'b001, 32'h6, 32'h0, rd, st0, a1);
    chk("LH6.lit", rd, 32'hFFFF_8877);
    run_check("LW2", 1'b0, 3'b010, 32'h2, 32'h0, rd, st0, a1);
    chk("LW2.stall.lit", 32'(st0), 32'd1);
    chk("LW2.lit", rd, 32'h6655_4433);
    run_check("LH3", 1'b0, 3'b001, 32'h3, 32'h0, rd, st0, a1);
    chk("LH3.lit", rd, 32'hFFFF_5544 & 32'h0000_FFFF | 32'h0000_0000);
    run_check("LHU3", 1'b0, 3'b101, 32'h3, 32'h0, rd, st0, a1);
    chk("LHU3.lit", rd, 32'h0000_5544);

    run_check("SB5", 1'b1, 3'b000, 32'h5, 32'h0000_00AB, rd, st0, a1);
    chk("SB5.w1", mem[1], 32'h8877_AB55);
    chk("SB5.w0", mem[0], 32'h4433_2211);
    chk("SB5.w2", mem[2], 32'h0000_0000);

    preload();
    run_check("SW6", 1'b1, 3'b010, 32'h6, 32'hDEAD_BEEF, rd, st0, a1);
    chk("SW6.w1", mem[1], 32'hBEEF_6655);
    chk("SW6.w2", mem[2], 32'h0000_DEAD);
    run_check("SWwrap", 1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, rd, st0, a1);
    chk("SWwrap.a1.lit", a1, 32'h0000_0000);
    chk("SWwrap.w15", mem[15], 32'h3344_0000);
    chk("SWwrap.w0", mem[0], 32'h4433_1122);

    run_check("ILLld", 1'b0, 3'b011, 32'h4, 32'h0, rd, st0, a1);
    run_check("ILLst", 1'b1, 3'b100, 32'h4, 32'hFFFF_FFFF, rd, st0, a1);
    chk("ILLst.w1", mem[1], 32'hBEEF_6655);

    // Instance without misaligned support
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.funct3 = 3'b010; bus0.addr = 32'h2;
    #1;
    chk("NOMIS.err", 32'(bus0.err), 32'd1);
    chk("NOMIS.stall", 32'(bus0.stall), 32'd0);
    chk("NOMIS.we", 32'(bus0.mem_WE), 32'd0);
    bus0.addr = 32'h4;
    #1;
    chk("NOMIS.al.err", 32'(bus0.err), 32'd0);
    chk("NOMIS.al.rdata", bus0.rdata, 32'h5A5A_5A5A);
    chk("NOMIS.al.addr", bus0.mem_A, 32'h0000_0004);
    bus0.req_we = 1'b1; bus0.addr = 32'h8; bus0.wdata = 32'h1234_5678;
    #1;
    chk("NOMIS.sw.we", 32'(bus0.mem_WE), 32'd1);
    chk("NOMIS.sw.wd", bus0.mem_WD, 32'h1234_5678);
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;

    // Reset asserted in the second half of a split store
    preload();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.funct3 = 3'b010;
    bus.addr = 32'h6; bus.wdata = 32'hDEAD_BEEF;
    #1;
    chk("RSPL.stall0", 32'(bus.stall), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("RSPL.stall", 32'(bus.stall), 32'd0);
    chk("RSPL.we", 32'(bus.mem_WE), 32'd0);
    chk("RSPL.err", 32'(bus.err), 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_store(32'h6, 2, 32'hDEAD_BEEF);
    chk("RSPL.w1", mem[1], 32'hBEEF_6655);
    chk("RSPL.w2", mem[2], 32'h0000_0000);
    run_check("RSPL.LW4", 1'b0, 3'b010, 32'h4, 32'h0, rd, st0, a1);
    chk("RSPL.idle", 32'(st0), 32'd0);

    // Randomized traffic against the byte model
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 9) == 0)
        f3 = we ? 3'($urandom_range(3, 7)) : ill_ld[$urandom_range(0, 2)];
      else
        f3 = we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      run_check($sformatf("rnd%0d", k), we, f3, $urandom, $urandom, rd, st0, a1);
    end
    for (int i = 0; i < 16; i++) chk($sformatf("final.w%0d", i), mem[i], ref_word(i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
